enc_onehot_stream: RTL and testbench
====================================

Name: enc_onehot_stream

Overview:
Parametrised, handshaked successor to the fixed 16-to-4 one-hot encoder, sitting between arbiter/request vectors and index-consuming datapaths.
- Accepts a p_nbits request vector on a val/rdy input.
- Emits bit indices on a val/rdy output.
- Strict mode: validates one-hot and returns a single index.
- Enumerate mode: serialises every set bit, lowest first, one index per output transaction.

Parameters:
p_nbits, 16, width of input vector; legal range >= 2, not required to be a power of two
p_idx_nbits, $clog2(p_nbits), width of output index; derived, never overridden

Ports:
clk       input   1            clock; all state updates on posedge
reset     input   1            synchronous, active-high reset
in_val    input   1            input vector valid
in_rdy    output  1            block can accept a vector
in_msg    input   p_nbits      request vector
in_mode   input   1            0 = strict one-hot, 1 = enumerate; sampled with in_msg
out_val   output  1            output index valid
out_rdy   input   1            consumer accepts index
out_idx   output  p_idx_nbits  encoded bit index
out_err   output  1            encoding error flag
out_last  output  1            final index for the current input vector

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset state, taking effect at the clk edge with reset=1:
  - FSM = IDLE, mask = 0, mode register = 0.
  - Outputs: out_val=0, out_idx=0, out_err=0, out_last=0.
  - in_rdy=0 while reset is high; in_rdy=1 in the first cycle after reset deasserts.
  - Reset mid-transaction discards the latched vector; no output transaction completes after it.
- FSM has two states, IDLE and SEND.
- IDLE:
  - in_rdy=1, out_val=0; out_idx/out_err/out_last driven 0.
  - in_val&&in_rdy: latch mask<=in_msg and mode<=in_mode; next state SEND.
- SEND:
  - in_rdy=0, out_val=1.
  - lsb = index of the lowest set bit of mask; lsb = 0 if mask == 0.
  - Strict mode (0):
    - onehot = mask nonzero with exactly one bit set.
    - out_err = !onehot.
    - out_idx = onehot ? lsb : 0, matching the legacy default-to-0 behaviour.
    - out_last = 1.
  - Enumerate mode (1):
    - mask == 0: out_idx=0, out_err=1, out_last=1.
    - Otherwise: out_idx=lsb, out_err=0, out_last=1 iff exactly one bit remains set.
  - out_val&&out_rdy:
    - Clear the lowest set bit: mask <= mask & (mask-1), no effect when mask is 0.
    - If out_last, go to IDLE; otherwise stay in SEND.
  - out_val&&!out_rdy: out_idx/out_err/out_last held stable; mask unchanged.
- Latency and throughput:
  - First index is valid in the cycle after input acceptance.
  - Strict mode: one output per input.
  - Enumerate mode: popcount(in_msg) outputs, or one error output for a zero vector.
  - Sustained input acceptance is at most one vector every (outputs+1) cycles.
  - No bypass: in_rdy is never asserted in SEND, including the cycle of the final out transaction.
- No combinational path from in_val/in_msg to out_*, or from out_rdy to in_rdy.
- Bit ordering: index 0 = in_msg[0]; the MSB index is p_nbits-1. Indices are reported strictly ascending within a vector.
- in_msg and in_mode are ignored when in_val=0 or in_rdy=0.

Test Plan:
- Reset, then strict mode, p_nbits=16, in_msg=16'h0001, then 16'h8000, out_rdy=1 -> out_idx=0 then 15; out_err=0, out_last=1; out_val one cycle after each accept.
- Strict mode, all 16 one-hot values, then 16'h0000 and 16'h0011 -> each one-hot value gives out_idx=i, err=0; 0000 gives idx=0, err=1; 0011 gives idx=0, err=1.
- Enumerate mode, in_msg=16'h8421, out_rdy=1 -> idx 0,5,10,15 on consecutive cycles, last=1 only on 15; in_rdy=0 throughout, reasserts the cycle after.
- Enumerate mode, in_msg=16'h0006, out_rdy low for 3 cycles then high -> idx=1 held stable with last=0 for 4 cycles, then idx=2 with last=1; in_val presented meanwhile is not accepted.
- Enumerate mode, in_msg=0 -> single out idx=0, err=1, last=1. Reset asserted while in SEND on 16'hFFFF after 2 outputs -> out_val=0 next cycle, in_rdy=1 after reset drops, no further indices.
- p_nbits=5 (p_idx_nbits=3), enumerate in_msg=5'b10010 -> idx 1 then 4; strict 5'b10000 -> idx 4, err 0.

Source files
------------

// File: rtl/enc_onehot_stream.sv
// enc_onehot_stream: handshaked bit-index encoder.
// A request vector is taken in on in_val/in_rdy. Strict mode (in_mode=0) returns
// a single index and flags anything that is not one-hot. Enumerate mode
// (in_mode=1) returns every set bit, lowest first, one index per output beat.
//
//   state | meaning
//   IDLE  | waiting for a vector; in_rdy high, no output pending
//   SEND  | presenting an index for the latched mask; in_rdy low
module enc_onehot_stream #(
    parameter int p_nbits     = 16,
    parameter int p_idx_nbits = $clog2(p_nbits)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [p_nbits-1:0]     in_msg,
    input  logic                   in_mode,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [p_idx_nbits-1:0] out_idx,
    output logic                   out_err,
    output logic                   out_last
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state;
    logic [p_nbits-1:0] mask;
    logic               mode;
    logic [p_nbits-1:0] mask_next;

    // Encodes a mask into {idx, err, last} for the given mode. Outputs are
    // registered, so this is evaluated on the value the mask is about to take.
    function automatic logic [p_idx_nbits+1:0] encode(input logic [p_nbits-1:0] v,
                                                      input logic               m);
        logic [p_idx_nbits-1:0] lsb;
        logic                   one;
        lsb = '0;
        for (int i = p_nbits - 1; i >= 0; i--) begin
            if (v[i]) begin
                lsb = p_idx_nbits'(i);
            end
        end
        one = (v != '0) && ((v & (v - p_nbits'(1))) == '0);
        if (!m) begin
            // Non-one-hot input reports index 0, as the fixed encoder did.
            return {(one ? lsb : {p_idx_nbits{1'b0}}), !one, 1'b1};
        end else if (v == '0) begin
            return {{p_idx_nbits{1'b0}}, 1'b1, 1'b1};
        end else begin
            return {lsb, 1'b0, one};
        end
    endfunction

    // Mask with its lowest set bit cleared; a zero mask stays zero.
    always_comb begin
        mask_next = mask & (mask - p_nbits'(1));
    end

    // Input ready only in IDLE and never while reset is held.
    assign in_rdy = (state == IDLE) && !reset;

    // Control FSM, mask/mode registers and registered output fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mask     <= '0;
            mode     <= 1'b0;
            out_val  <= 1'b0;
            out_idx  <= '0;
            out_err  <= 1'b0;
            out_last <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_val) begin
                        state   <= SEND;
                        mask    <= in_msg;
                        mode    <= in_mode;
                        out_val <= 1'b1;
                        {out_idx, out_err, out_last} <= encode(in_msg, in_mode);
                    end
                end
                SEND: begin
                    if (out_rdy) begin
                        mask <= mask_next;
                        if (out_last) begin
                            state    <= IDLE;
                            out_val  <= 1'b0;
                            out_idx  <= '0;
                            out_err  <= 1'b0;
                            out_last <= 1'b0;
                        end else begin
                            {out_idx, out_err, out_last} <= encode(mask_next, mode);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    out_val <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc_onehot_stream.sv
// Directed bench for enc_onehot_stream at p_nbits=16 and p_nbits=5.
module tb_enc_onehot_stream;

    logic        clk = 1'b0;
    logic        reset;

    logic        in_val, in_rdy, in_mode, out_val, out_rdy, out_err, out_last;
    logic [15:0] in_msg;
    logic [3:0]  out_idx;

    logic        v5_in_val, v5_in_rdy, v5_in_mode, v5_out_val, v5_out_rdy, v5_out_err, v5_out_last;
    logic [4:0]  v5_in_msg;
    logic [2:0]  v5_out_idx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    enc_onehot_stream #(.p_nbits(16)) dut (
        .clk(clk), .reset(reset),
        .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg), .in_mode(in_mode),
        .out_val(out_val), .out_rdy(out_rdy), .out_idx(out_idx),
        .out_err(out_err), .out_last(out_last)
    );

    enc_onehot_stream #(.p_nbits(5)) dut5 (
        .clk(clk), .reset(reset),
        .in_val(v5_in_val), .in_rdy(v5_in_rdy), .in_msg(v5_in_msg), .in_mode(v5_in_mode),
        .out_val(v5_out_val), .out_rdy(v5_out_rdy), .out_idx(v5_out_idx),
        .out_err(v5_out_err), .out_last(v5_out_last)
    );

    // Tasks start and end just after a negedge; outputs are sampled there.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic accept16(input logic [15:0] msg, input logic mode);
        in_val  = 1'b1;
        in_msg  = msg;
        in_mode = mode;
        step();
        in_val  = 1'b0;
    endtask

    task automatic accept5(input logic [4:0] msg, input logic mode);
        v5_in_val  = 1'b1;
        v5_in_msg  = msg;
        v5_in_mode = mode;
        step();
        v5_in_val  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if ({out_val, out_idx, out_err, out_last, in_rdy} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_state: got val/idx/err/last/rdy=%b required 00000000",
                     {out_val, out_idx, out_err, out_last, in_rdy});
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_rdy: got %b required 1", in_rdy);
        end
    endtask

    task automatic test_strict_basic();
        logic [15:0] msgs [2] = '{16'h0001, 16'h8000};
        logic [3:0]  exps [2] = '{4'd0, 4'd15};
        for (int k = 0; k < 2; k++) begin
            accept16(msgs[k], 1'b0);
            n_checks++;
            if ({out_val, out_idx, out_err, out_last, in_rdy} !== {1'b1, exps[k], 1'b0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL strict_basic[%0d]: got val/idx/err/last/rdy=%b required %b", k,
                         {out_val, out_idx, out_err, out_last, in_rdy}, {1'b1, exps[k], 3'b010});
            end
            step();
            n_checks++;
            if ({out_val, in_rdy} !== 2'b01) begin
                n_fail++;
                $display("FAIL strict_basic_done[%0d]: got val/rdy=%b required 01", k, {out_val, in_rdy});
            end
        end
    endtask

    task automatic test_strict_all();
        logic [15:0] bad  [2] = '{16'h0000, 16'h0011};
        for (int i = 0; i < 16; i++) begin
            accept16(16'h0001 << i, 1'b0);
            n_checks++;
            if ({out_val, out_idx, out_err, out_last} !== {1'b1, 4'(i), 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL strict_onehot[%0d]: got val/idx/err/last=%b required %b", i,
                         {out_val, out_idx, out_err, out_last}, {1'b1, 4'(i), 2'b01});
            end
            step();
        end
        for (int k = 0; k < 2; k++) begin
            accept16(bad[k], 1'b0);
            n_checks++;
            if ({out_val, out_idx, out_err, out_last} !== 7'b1_0000_11) begin
                n_fail++;
                $display("FAIL strict_err[%0d]: got val/idx/err/last=%b required 1000011", k,
                         {out_val, out_idx, out_err, out_last});
            end
            step();
        end
    endtask

    task automatic test_enumerate();
        logic [3:0] exps [4] = '{4'd0, 4'd5, 4'd10, 4'd15};
        accept16(16'h8421, 1'b1);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({out_val, out_idx, out_err, out_last, in_rdy} !== {1'b1, exps[k], 1'b0, (k == 3), 1'b0}) begin
                n_fail++;
                $display("FAIL enum_8421[%0d]: got val/idx/err/last/rdy=%b required %b", k,
                         {out_val, out_idx, out_err, out_last, in_rdy},
                         {1'b1, exps[k], 1'b0, (k == 3), 1'b0});
            end
            step();
        end
        n_checks++;
        if ({out_val, in_rdy} !== 2'b01) begin
            n_fail++;
            $display("FAIL enum_8421_done: got val/rdy=%b required 01", {out_val, in_rdy});
        end
    endtask

    task automatic test_backpressure();
        out_rdy = 1'b0;
        accept16(16'h0006, 1'b1);
        in_val  = 1'b1;
        in_msg  = 16'h0001;
        in_mode = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) out_rdy = 1'b1;
            n_checks++;
            if ({out_val, out_idx, out_err, out_last, in_rdy} !== 8'b1_0001_000) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got val/idx/err/last/rdy=%b required 10001000", c,
                         {out_val, out_idx, out_err, out_last, in_rdy});
            end
            step();
        end
        n_checks++;
        if ({out_val, out_idx, out_err, out_last} !== 7'b1_0010_01) begin
            n_fail++;
            $display("FAIL stall_second: got val/idx/err/last=%b required 1001001",
                     {out_val, out_idx, out_err, out_last});
        end
        in_val = 1'b0;
        step();
        step();
        n_checks++;
        if (out_val !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_no_accept: got out_val=%b required 0", out_val);
        end
    endtask

    task automatic test_enum_zero();
        accept16(16'h0000, 1'b1);
        n_checks++;
        if ({out_val, out_idx, out_err, out_last} !== 7'b1_0000_11) begin
            n_fail++;
            $display("FAIL enum_zero: got val/idx/err/last=%b required 1000011",
                     {out_val, out_idx, out_err, out_last});
        end
        step();
        n_checks++;
        if (out_val !== 1'b0) begin
            n_fail++;
            $display("FAIL enum_zero_single: got out_val=%b required 0", out_val);
        end
    endtask

    task automatic test_reset_mid();
        accept16(16'hFFFF, 1'b1);
        step();
        step();
        n_checks++;
        if ({out_val, out_idx} !== 5'b1_0010) begin
            n_fail++;
            $display("FAIL midreset_pre: got val/idx=%b required 10010", {out_val, out_idx});
        end
        reset = 1'b1;
        step();
        n_checks++;
        if ({out_val, in_rdy} !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_during: got val/rdy=%b required 00", {out_val, in_rdy});
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_rdy: got %b required 1", in_rdy);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (out_val !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_quiet[%0d]: got out_val=%b required 0", c, out_val);
            end
        end
    endtask

    task automatic test_width5();
        accept5(5'b10010, 1'b1);
        n_checks++;
        if ({v5_out_val, v5_out_idx, v5_out_err, v5_out_last} !== 6'b1_001_00) begin
            n_fail++;
            $display("FAIL w5_enum_first: got val/idx/err/last=%b required 100100",
                     {v5_out_val, v5_out_idx, v5_out_err, v5_out_last});
        end
        step();
        n_checks++;
        if ({v5_out_val, v5_out_idx, v5_out_err, v5_out_last} !== 6'b1_100_01) begin
            n_fail++;
            $display("FAIL w5_enum_second: got val/idx/err/last=%b required 110001",
                     {v5_out_val, v5_out_idx, v5_out_err, v5_out_last});
        end
        step();
        accept5(5'b10000, 1'b0);
        n_checks++;
        if ({v5_out_val, v5_out_idx, v5_out_err, v5_out_last} !== 6'b1_100_01) begin
            n_fail++;
            $display("FAIL w5_strict: got val/idx/err/last=%b required 110001",
                     {v5_out_val, v5_out_idx, v5_out_err, v5_out_last});
        end
        step();
    endtask

    initial begin
        reset      = 1'b1;
        in_val     = 1'b0;
        in_msg     = '0;
        in_mode    = 1'b0;
        out_rdy    = 1'b1;
        v5_in_val  = 1'b0;
        v5_in_msg  = '0;
        v5_in_mode = 1'b0;
        v5_out_rdy = 1'b1;
        @(negedge clk);
        test_reset();
        test_strict_basic();
        test_strict_all();
        test_enumerate();
        test_backpressure();
        test_enum_zero();
        test_reset_mid();
        test_width5();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
